// File: rtl/execute_stage.sv
// Execute stage: ALU plus Z/N/C condition codes, feeding a single EX/MEM pipeline register.
// A full register that is stalled holds everything and refuses new work from decode.
module execute_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int OP_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     op1,
  input  logic [DATA_W-1:0]     R_op2,
  input  logic [DATA_W-1:0]     I_op2,
  input  logic [REG_ADDR_W-1:0] write_addr,
  input  logic [OP_W-1:0]       aluOp,
  input  logic                  RegWR,
  input  logic                  aluSrc,
  input  logic                  MemWR,
  input  logic                  MemR,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     alu_result,
  output logic [DATA_W-1:0]     store_data,
  output logic [REG_ADDR_W-1:0] ex_write_addr,
  output logic                  ex_RegWR,
  output logic                  ex_MemWR,
  output logic                  ex_MemR,
  output logic [2:0]            flags
);

  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_INC  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DEC  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MOV  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_SETC = OP_W'(11);
  localparam logic [OP_W-1:0] OP_CLRC = OP_W'(12);

  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] res;
  logic [DATA_W:0]   wide;
  logic [3:0]        shamt;
  logic              c_next;
  logic              upd_zn;
  logic [2:0]        flags_next;
  logic              accept;

  assign in_ready = !stall || !ex_valid;
  assign accept   = in_valid && in_ready;
  assign opb      = aluSrc ? I_op2 : R_op2;
  assign shamt    = opb[3:0];

  // One extra bit on the working value carries the carry/borrow or the bit shifted out.
  always_comb begin
    res    = '0;
    wide   = '0;
    upd_zn = 1'b0;
    c_next = flags[2];
    case (aluOp)
      OP_NOT: begin
        res    = ~op1;
        upd_zn = 1'b1;
      end
      OP_INC: begin
        wide   = {1'b0, op1} + {{DATA_W{1'b0}}, 1'b1};
        res    = wide[DATA_W-1:0];
        c_next = wide[DATA_W];
        upd_zn = 1'b1;
      end
      OP_DEC: begin
        wide   = {1'b0, op1} - {{DATA_W{1'b0}}, 1'b1};
        res    = wide[DATA_W-1:0];
        c_next = wide[DATA_W];
        upd_zn = 1'b1;
      end
      OP_MOV: res = opb;
      OP_ADD: begin
        wide   = {1'b0, op1} + {1'b0, opb};
        res    = wide[DATA_W-1:0];
        c_next = wide[DATA_W];
        upd_zn = 1'b1;
      end
      OP_SUB: begin
        wide   = {1'b0, op1} - {1'b0, opb};
        res    = wide[DATA_W-1:0];
        c_next = wide[DATA_W];
        upd_zn = 1'b1;
      end
      OP_AND: begin
        res    = op1 & opb;
        upd_zn = 1'b1;
      end
      OP_OR: begin
        res    = op1 | opb;
        upd_zn = 1'b1;
      end
      OP_SHL: begin
        res    = op1;
        upd_zn = 1'b1;
        if (shamt != 4'd0) begin
          wide   = {1'b0, op1} << shamt;
          res    = wide[DATA_W-1:0];
          c_next = wide[DATA_W];
        end
      end
      OP_SHR: begin
        res    = op1;
        upd_zn = 1'b1;
        if (shamt != 4'd0) begin
          wide   = {op1, 1'b0} >> shamt;
          res    = wide[DATA_W:1];
          c_next = wide[0];
        end
      end
      OP_SETC: c_next = 1'b1;
      OP_CLRC: c_next = 1'b0;
      default: res = '0;
    endcase
    flags_next = {c_next,
                  upd_zn ? res[DATA_W-1] : flags[1],
                  upd_zn ? (res == '0)   : flags[0]};
  end

  // A bubble clears valid and control but leaves the data fields as they were.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid      <= 1'b0;
      alu_result    <= '0;
      store_data    <= '0;
      ex_write_addr <= '0;
      ex_RegWR      <= 1'b0;
      ex_MemWR      <= 1'b0;
      ex_MemR       <= 1'b0;
      flags         <= 3'b000;
    end else if (accept) begin
      ex_valid      <= 1'b1;
      alu_result    <= res;
      store_data    <= R_op2;
      ex_write_addr <= write_addr;
      ex_RegWR      <= RegWR;
      ex_MemWR      <= MemWR;
      ex_MemR       <= MemR;
      flags         <= flags_next;
    end else if (in_ready) begin
      ex_valid <= 1'b0;
      ex_RegWR <= 1'b0;
      ex_MemWR <= 1'b0;
      ex_MemR  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: fixed vector table, stall/reset sequences, then random traffic
// compared against an arithmetic reference of the ALU and EX/MEM register.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, in_ready;
  logic [15:0] op1, R_op2, I_op2;
  logic [2:0]  write_addr;
  logic [3:0]  aluOp;
  logic        RegWR, aluSrc, MemWR, MemR;
  logic        ex_valid;
  logic [15:0] alu_result, store_data;
  logic [2:0]  ex_write_addr;
  logic        ex_RegWR, ex_MemWR, ex_MemR;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;

  execute_stage #(.DATA_W(16), .REG_ADDR_W(3), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .in_ready(in_ready),
    .op1(op1), .R_op2(R_op2), .I_op2(I_op2), .write_addr(write_addr), .aluOp(aluOp),
    .RegWR(RegWR), .aluSrc(aluSrc), .MemWR(MemWR), .MemR(MemR),
    .ex_valid(ex_valid), .alu_result(alu_result), .store_data(store_data),
    .ex_write_addr(ex_write_addr), .ex_RegWR(ex_RegWR), .ex_MemWR(ex_MemWR),
    .ex_MemR(ex_MemR), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; bit st; int op; int a; int r; int im; bit src; int wa;
    bit rw; bit mw; bit mr;
    int e_res; int e_flags; bit e_valid; bit c_res;
  } vec_t;

  // reference state of the EX/MEM register
  bit m_valid;
  int m_res, m_store, m_wa, m_ctl, m_flags;
  bit m_res_known;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic void ref_alu(input int op, input int a, input int b, input int fin,
                                  output int res, output int fout, output bit known);
    int c, n, z, s, sh;
    bit zn;
    c = (fin >> 2) & 1; zn = 0; known = 1; res = 0;
    case (op)
      1: begin res = (~a) & 'hFFFF; zn = 1; end
      2: begin s = a + 1; res = s & 'hFFFF; c = (s > 'hFFFF) ? 1 : 0; zn = 1; end
      3: begin res = (a - 1) & 'hFFFF; c = (a == 0) ? 1 : 0; zn = 1; end
      4: res = b;
      5: begin s = a + b; res = s & 'hFFFF; c = (s > 'hFFFF) ? 1 : 0; zn = 1; end
      6: begin res = (a - b) & 'hFFFF; c = (a < b) ? 1 : 0; zn = 1; end
      7: begin res = a & b; zn = 1; end
      8: begin res = a | b; zn = 1; end
      9: begin
        sh = b % 16; zn = 1;
        if (sh == 0) res = a;
        else begin res = (a << sh) & 'hFFFF; c = (a >> (16 - sh)) & 1; end
      end
      10: begin
        sh = b % 16; zn = 1;
        if (sh == 0) res = a;
        else begin res = a >> sh; c = (a >> (sh - 1)) & 1; end
      end
      11: begin c = 1; known = 0; end
      12: begin c = 0; known = 0; end
      default: res = 0;
    endcase
    z = zn ? ((res == 0) ? 1 : 0) : (fin & 1);
    n = zn ? ((res >> 15) & 1) : ((fin >> 1) & 1);
    fout = (c << 2) | (n << 1) | z;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_res = 0; m_store = 0; m_wa = 0; m_ctl = 0; m_flags = 0; m_res_known = 1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ex_valid"}, int'(ex_valid), int'(m_valid));
    chk({tag, ".flags"}, int'(flags), m_flags);
    chk({tag, ".ctl"}, int'({ex_RegWR, ex_MemWR, ex_MemR}), m_ctl);
    if (m_res_known) chk({tag, ".alu_result"}, int'(alu_result), m_res);
    if (m_valid) begin
      chk({tag, ".store_data"}, int'(store_data), m_store);
      chk({tag, ".ex_write_addr"}, int'(ex_write_addr), m_wa);
    end
  endtask

  // One clock: drive at negedge, check in_ready, advance the reference at the edge, check after it.
  task automatic apply(input vec_t t, input string tag);
    bit ready, known;
    int b, res, fout;
    @(negedge clk);
    in_valid = t.v; stall = t.st; aluOp = 4'(t.op); op1 = 16'(t.a); R_op2 = 16'(t.r);
    I_op2 = 16'(t.im); aluSrc = t.src; write_addr = 3'(t.wa);
    RegWR = t.rw; MemWR = t.mw; MemR = t.mr;
    #1;
    ready = !t.st || !m_valid;
    chk({tag, ".in_ready"}, int'(in_ready), int'(ready));
    @(posedge clk);
    if (t.v && ready) begin
      b = t.src ? t.im : t.r;
      ref_alu(t.op, t.a, b, m_flags, res, fout, known);
      m_valid = 1; m_store = t.r; m_wa = t.wa;
      m_ctl = (int'(t.rw) << 2) | (int'(t.mw) << 1) | int'(t.mr);
      m_flags = fout; m_res_known = known;
      if (known) m_res = res;
    end else if (ready) begin
      m_valid = 0; m_ctl = 0;
    end
    #1;
    check_outputs(tag);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 'hFFFF;
      2: return 'h8000;
      3: return $urandom_range(0, 16);
      default: return int'($urandom_range(0, 'hFFFF));
    endcase
  endfunction

  vec_t tbl[18];
  vec_t t;

  initial begin
    //            v st op  a        r        im      src wa rw mw mr  e_res    e_fl   ev cres
    tbl[0]  = '{1, 0, 5, 'hFFFF, 'h0001, 0,      0, 0, 0, 0, 0, 'h0000, 3'b101, 1, 1};
    tbl[1]  = '{1, 0, 6, 3,      0,      5,      1, 6, 1, 0, 0, 'hFFFE, 3'b110, 1, 1};
    tbl[2]  = '{1, 0, 9, 'h8001, 0,      1,      1, 1, 1, 0, 0, 'h0002, 3'b100, 1, 1};
    tbl[3]  = '{1, 0, 10,'h8001, 0,      0,      1, 2, 1, 0, 0, 'h8001, 3'b110, 1, 1};
    tbl[4]  = '{1, 0, 12,'h1234, 0,      0,      1, 0, 0, 0, 0, 0,      3'b010, 1, 0};
    tbl[5]  = '{1, 0, 11,'h1234, 0,      0,      1, 0, 0, 0, 0, 0,      3'b110, 1, 0};
    tbl[6]  = '{1, 0, 4, 'h1234, 'h5555, 0,      1, 3, 1, 0, 0, 'h0000, 3'b110, 1, 1};
    tbl[7]  = '{0, 0, 5, 'h1111, 'h1111, 0,      0, 0, 0, 0, 0, 'h0000, 3'b110, 0, 1};
    tbl[8]  = '{1, 0, 12,0,      0,      0,      0, 0, 0, 0, 0, 0,      3'b010, 1, 0};
    tbl[9]  = '{1, 0, 2, 'hFFFF, 0,      0,      0, 4, 1, 0, 0, 'h0000, 3'b101, 1, 1};
    tbl[10] = '{1, 0, 3, 0,      0,      0,      0, 5, 1, 0, 0, 'hFFFF, 3'b110, 1, 1};
    tbl[11] = '{1, 0, 7, 'hF0F0, 'h0F0F, 'hFFFF, 0, 1, 1, 0, 0, 'h0000, 3'b101, 1, 1};
    tbl[12] = '{1, 0, 8, 'h8000, 'h0001, 0,      0, 2, 1, 0, 0, 'h8001, 3'b110, 1, 1};
    tbl[13] = '{1, 0, 1, 0,      0,      0,      0, 3, 1, 0, 0, 'hFFFF, 3'b110, 1, 1};
    tbl[14] = '{1, 0, 0, 'h1234, 'h4321, 0,      0, 0, 0, 0, 0, 'h0000, 3'b110, 1, 1};
    tbl[15] = '{1, 0, 14,'h1234, 'h4321, 0,      0, 0, 0, 0, 0, 'h0000, 3'b110, 1, 1};
    tbl[16] = '{0, 1, 5, 'h7777, 0,      0,      0, 0, 0, 0, 0, 'h0000, 3'b110, 1, 1};
    tbl[17] = '{1, 0, 5, 'h1000, 'hBEEF, 'h0010, 1, 0, 0, 1, 0, 'h1010, 3'b000, 1, 1};

    rst = 1'b0; in_valid = 0; stall = 0; op1 = 0; R_op2 = 0; I_op2 = 0; write_addr = 0;
    aluOp = 0; RegWR = 0; aluSrc = 0; MemWR = 0; MemR = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ex_valid", int'(ex_valid), 0);
    chk("reset.flags", int'(flags), 0);
    chk("reset.alu_result", int'(alu_result), 0);
    chk("reset.ctl", int'({ex_RegWR, ex_MemWR, ex_MemR, ex_write_addr}), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.const_valid", i), int'(ex_valid), int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.const_flags", i), int'(flags), tbl[i].e_flags);
      if (tbl[i].c_res) chk($sformatf("tbl%0d.const_result", i), int'(alu_result), tbl[i].e_res);
    end
    chk("tbl1_dest.ex_MemWR", int'(ex_MemWR), 1);

    // Stall hold with a pending ADD, then release.
    t = '{1, 0, 5, 5, 3, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0};
    apply(t, "fill");
    chk("fill.result", int'(alu_result), 8);
    for (int i = 0; i < 3; i++) begin
      t = '{1, 1, 5, 'h7FFF, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0};
      apply(t, "stall");
      chk("stall.in_ready", int'(in_ready), 0);
      chk("stall.result_held", int'(alu_result), 8);
      chk("stall.flags_held", int'(flags), 3'b000);
      chk("stall.wa_held", int'(ex_write_addr), 7);
    end
    t = '{1, 0, 5, 'h7FFF, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0};
    apply(t, "unstall");
    chk("unstall.result", int'(alu_result), 'h8000);
    chk("unstall.flags", int'(flags), 3'b010);
    chk("unstall.wa", int'(ex_write_addr), 2);

    // Empty register accepts even while stalled.
    t = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    apply(t, "bubble");
    chk("bubble.valid", int'(ex_valid), 0);
    t = '{1, 1, 5, 2, 2, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0};
    apply(t, "stall_empty");
    chk("stall_empty.valid", int'(ex_valid), 1);
    chk("stall_empty.result", int'(alu_result), 4);
    chk("stall_empty.MemR", int'(ex_MemR), 1);

    // Asynchronous reset in the middle of a cycle.
    t = '{1, 0, 6, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0};
    apply(t, "pre_rst");
    chk("pre_rst.flags", int'(flags), 3'b110);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst.ex_valid", int'(ex_valid), 0);
    chk("async_rst.flags", int'(flags), 0);
    chk("async_rst.result", int'(alu_result), 0);
    chk("async_rst.ctl", int'({ex_RegWR, ex_MemWR, ex_MemR, ex_write_addr}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    t = '{1, 0, 5, 'h0001, 'h0002, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0};
    apply(t, "post_rst");
    chk("post_rst.result", int'(alu_result), 3);
    chk("post_rst.flags", int'(flags), 3'b000);

    for (int i = 0; i < 400; i++) begin
      t.v = ($urandom_range(0, 3) != 0);
      t.st = ($urandom_range(0, 2) == 0);
      t.op = int'($urandom_range(0, 15));
      t.a = pick(); t.r = pick(); t.im = pick();
      t.src = 1'($urandom_range(0, 1));
      t.wa = int'($urandom_range(0, 7));
      t.rw = 1'($urandom_range(0, 1));
      t.mw = 1'($urandom_range(0, 1));
      t.mr = 1'($urandom_range(0, 1));
      apply(t, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
